// File: rtl/sw_pkg.sv
// sw_pkg: shared types for the packet-switch input side.
//   flit_t  - 2-bit flit type carried alongside every payload word.
//   state_t - input buffer manager FSM states.
package sw_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AREQ = 2'd1,
        XFER = 2'd2,
        DROP = 2'd3
    } state_t;

endpackage

// File: rtl/isbm_param_if.sv
// isbm_param_if: flit, arbiter and error-pulse bundle of one switch input port.
//   master : traffic source / arbiter side (drives in_*, ack)
//   slave  : input buffer manager side (drives in_ready, out_*, req, *_err)
interface isbm_param_if
    import sw_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int W     = 16
);
    logic             in_valid;
    flit_t            in_type;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    flit_t            out_type;
    logic [W-1:0]     out_data;
    logic [NPORT-1:0] req;
    logic             ack;
    logic             timeout_err;
    logic             len_err;
    logic             stray_err;

    modport master (
        output in_valid, in_type, in_data, ack,
        input  in_ready, out_valid, out_type, out_data, req,
               timeout_err, len_err, stray_err
    );

    modport slave (
        input  in_valid, in_type, in_data, ack,
        output in_ready, out_valid, out_type, out_data, req,
               timeout_err, len_err, stray_err
    );
endinterface

// File: rtl/sw_fifo.sv
// sw_fifo: show-ahead synchronous FIFO.
//   clk, rst          clock, synchronous active-high reset (pointers only)
//   wr_en, wr_data    push; ignored while full
//   rd_en             pop of the current head; ignored while empty
//   rd_data           current head word (valid when !empty)
//   full, empty       occupancy flags
module sw_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_ok;
    logic         rd_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/isbm_param.sv
// isbm_param: input-side buffer manager for one switch port.
// Buffers incoming flits, decodes the destination from the HEAD flit,
// requests the crossbar with a one-hot req, and streams the packet after
// grant. Abandons grant waits after TIMEOUT cycles, truncates packets
// longer than MAXLEN flits, and discards flits that arrive without a HEAD.
//   clk, rst   clock, synchronous active-high reset
//   bus        isbm_param_if slave: in_* write side, out_* stream side,
//              req/ack arbiter handshake, one-cycle error pulses
module isbm_param
    import sw_pkg::*;
#(
    parameter int NPORT    = 4,
    parameter int W        = 16,
    parameter int DEPTH    = 8,
    parameter int DEST_LSB = 0,
    parameter int TIMEOUT  = 64,
    parameter int MAXLEN   = 16
) (
    input  logic        clk,
    input  logic        rst,
    isbm_param_if.slave bus
);
    localparam int DW  = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int WCW = $clog2(TIMEOUT + 2);
    localparam int LCW = $clog2(MAXLEN + 2);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LCW-1:0]   LEN_LAST  = LCW'((MAXLEN > 0) ? MAXLEN - 1 : 0);
    localparam logic [WCW-1:0]   WCNT_ONE  = WCW'(1);
    localparam logic [LCW-1:0]   FCNT_ONE  = LCW'(1);
    localparam logic [NPORT-1:0] REQ_ONE   = NPORT'(1);

    state_t           state;
    state_t           state_n;
    logic [DW-1:0]    dest;
    logic [WCW-1:0]   wcnt;
    logic [LCW-1:0]   fcnt;

    logic             f_wr;
    logic             re;
    logic [W+1:0]     f_rdata;
    logic             f_full;
    logic             f_empty;
    flit_t            head_type;
    logic [W-1:0]     head_data;
    logic             visible;
    logic             latch_dest;
    logic             len_hit;

    logic             out_valid;
    logic [NPORT-1:0] req;
    logic             terr;
    logic             lerr;
    logic             serr;

    // NONE flits are never buffered; nothing is accepted while in reset.
    assign bus.in_ready = !f_full && !rst;
    assign f_wr         = bus.in_valid && bus.in_ready && (bus.in_type != NONE);

    sw_fifo #(
        .W     (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (f_wr),
        .wr_data ({bus.in_type, bus.in_data}),
        .rd_en   (re),
        .rd_data (f_rdata),
        .full    (f_full),
        .empty   (f_empty)
    );

    assign head_type    = flit_t'(f_rdata[W+1:W]);
    assign head_data    = f_rdata[W-1:0];
    assign visible      = !f_empty && !rst;
    assign bus.out_type = visible ? head_type : NONE;
    assign bus.out_data = visible ? head_data : '0;

    // fcnt is the number of flits already popped for this packet, so the
    // flit being popped now is the MAXLEN-th when fcnt == MAXLEN-1.
    assign len_hit = (MAXLEN != 0) && (fcnt == LEN_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Counters clear while IDLE, which is the only way into AREQ.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            wcnt <= '0;
            fcnt <= '0;
        end else begin
            if (state == AREQ && wcnt != '1) wcnt <= wcnt + WCNT_ONE;
            if (re && fcnt != '1)            fcnt <= fcnt + FCNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_dest) dest <= head_data[DEST_LSB +: DW];
    end

    always_comb begin
        state_n    = state;
        re         = 1'b0;
        out_valid  = 1'b0;
        req        = '0;
        terr       = 1'b0;
        lerr       = 1'b0;
        serr       = 1'b0;
        latch_dest = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (!f_empty) begin
                        if (head_type == HEAD) begin
                            latch_dest = 1'b1;
                            state_n    = AREQ;
                        end else begin
                            re   = 1'b1;
                            serr = 1'b1;
                        end
                    end
                end
                AREQ: begin
                    req = REQ_ONE << dest;
                    if (bus.ack) begin
                        re        = 1'b1;
                        out_valid = 1'b1;
                        if (len_hit) begin
                            lerr    = 1'b1;
                            state_n = DROP;
                        end else begin
                            state_n = XFER;
                        end
                    end else if (TIMEOUT != 0 && wcnt == WAIT_LAST) begin
                        terr    = 1'b1;
                        state_n = DROP;
                    end
                end
                XFER: begin
                    req = REQ_ONE << dest;
                    if (!f_empty) begin
                        re        = 1'b1;
                        out_valid = 1'b1;
                        if (head_type == TAIL) begin
                            state_n = IDLE;
                        end else if (len_hit) begin
                            lerr    = 1'b1;
                            state_n = DROP;
                        end
                    end
                end
                DROP: begin
                    if (!f_empty) begin
                        re = 1'b1;
                        if (head_type == TAIL) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.req         = req;
    assign bus.timeout_err = terr;
    assign bus.len_err     = lerr;
    assign bus.stray_err   = serr;
endmodule
